// File: rtl/apb_vgachargen_ctrl_pkg.sv
// Shared constants and types for the VGA character generator APB front end:
// memory depths, region base addresses, region and FSM state encodings.
package vgachargen_pkg;

    localparam int MAP_DEPTH = 2400;
    localparam int CT_DEPTH  = 128;

    localparam logic [31:0] COL_BASE = 32'h0000_0000;
    localparam logic [31:0] CH_BASE  = 32'h0000_4000;
    localparam logic [31:0] CT_BASE  = 32'h0000_8000;

    typedef enum logic [1:0] {COL, CH, CT, NONE} region_e;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

endpackage

// File: rtl/apb_vgachargen_ctrl_if.sv
// APB3 bus bundle between the CPU fabric and the character generator control block.
interface apb_vgachargen_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [31:0]       pwdata_i;
    logic [31:0]       prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_vgachargen_ctrl_decode.sv
// Combinational APB byte address decode into memory region, entry index,
// glyph word lane and an out-of-range error flag.
module apb_vgachargen_decode
    import vgachargen_pkg::*;
#(
    parameter int  ADDR_W    = 16,
    parameter int  MAP_DEPTH = 2400,
    parameter int  CT_DEPTH  = 128,
    localparam int MAP_AW    = $clog2(MAP_DEPTH),
    localparam int CT_AW     = $clog2(CT_DEPTH)
) (
    input  logic [ADDR_W-1:0] paddr,
    output region_e           region,
    output logic [MAP_AW-1:0] map_idx,
    output logic [CT_AW-1:0]  ct_idx,
    output logic [1:0]        word,
    output logic              err
);
    logic [11:0] idx_full;
    logic        unused_addr;

    assign idx_full    = paddr[13:2];
    assign unused_addr = ^paddr[1:0];

    always_comb begin
        region  = NONE;
        err     = 1'b1;
        map_idx = idx_full[MAP_AW-1:0];
        ct_idx  = paddr[CT_AW+3:4];
        word    = paddr[3:2];
        // Map windows are 16 KiB apart; only the first MAP_DEPTH words are backed.
        if (paddr[ADDR_W-1:14] == COL_BASE[ADDR_W-1:14]) begin
            region = COL;
            err    = (int'(idx_full) >= MAP_DEPTH);
        end else if (paddr[ADDR_W-1:14] == CH_BASE[ADDR_W-1:14]) begin
            region = CH;
            err    = (int'(idx_full) >= MAP_DEPTH);
        end else if (paddr[ADDR_W-1:CT_AW+4] == CT_BASE[ADDR_W-1:CT_AW+4]) begin
            region = CT;
            err    = 1'b0;
        end
    end
endmodule

// File: rtl/apb_vgachargen_ctrl.sv
// APB3 slave driving the colour map, character map and glyph table write/read ports.
// Memory address is loaded during the APB setup phase so synchronous read data is ready in WAIT.
module apb_vgachargen_ctrl
    import vgachargen_pkg::*;
#(
    parameter int  ADDR_W    = 16,
    parameter int  MAP_DEPTH = vgachargen_pkg::MAP_DEPTH,
    parameter int  CT_DEPTH  = vgachargen_pkg::CT_DEPTH,
    localparam int MAP_AW    = $clog2(MAP_DEPTH),
    localparam int CT_AW     = $clog2(CT_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    apb_vgachargen_ctrl_if.slave        apb,
    output logic [7:0]                  col_map_data_o,
    output logic [MAP_AW-1:0]           col_map_addr_o,
    output logic                        col_map_wen_o,
    input  logic [7:0]                  col_map_data_i,
    output logic [7:0]                  ch_map_data_o,
    output logic [MAP_AW-1:0]           ch_map_addr_o,
    output logic                        ch_map_wen_o,
    input  logic [7:0]                  ch_map_data_i,
    output logic [127:0]                ch_t_data_o,
    output logic [CT_AW-1:0]            ch_t_addr_o,
    output logic                        ch_t_wen_o,
    input  logic [127:0]                ch_t_data_i
);
    state_e            state_q, state_d;
    region_e           dec_region, rgn_q;
    logic [MAP_AW-1:0] dec_map_idx;
    logic [CT_AW-1:0]  dec_ct_idx;
    logic [1:0]        dec_word, word_q;
    logic              dec_err, wr_q, err_q;
    logic              access, setup_ld, map_wr, bad, start_wait, rd_cap, ct_wr;
    logic [127:0]      ct_merged;

    apb_vgachargen_decode #(
        .ADDR_W    (ADDR_W),
        .MAP_DEPTH (MAP_DEPTH),
        .CT_DEPTH  (CT_DEPTH)
    ) u_decode (
        .paddr   (apb.paddr_i),
        .region  (dec_region),
        .map_idx (dec_map_idx),
        .ct_idx  (dec_ct_idx),
        .word    (dec_word),
        .err     (dec_err)
    );

    assign access        = apb.psel_i & apb.penable_i;
    assign apb.pready_o  = (state_q == DONE);
    assign apb.pslverr_o = (state_q == DONE) & err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        setup_ld   = 1'b0;
        map_wr     = 1'b0;
        bad        = 1'b0;
        start_wait = 1'b0;
        rd_cap     = 1'b0;
        ct_wr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb.psel_i && !apb.penable_i) begin
                    setup_ld = 1'b1;
                end else if (access) begin
                    if (dec_err) begin
                        bad     = 1'b1;
                        state_d = DONE;
                    end else if (apb.pwrite_i && dec_region != CT) begin
                        map_wr  = 1'b1;
                        state_d = DONE;
                    end else begin
                        start_wait = 1'b1;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                // A dropped penable abandons the transfer without touching memory.
                if (!access) begin
                    state_d = IDLE;
                end else begin
                    ct_wr   = wr_q;
                    rd_cap  = !wr_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ct_merged = ch_t_data_i;
        ct_merged[{word_q, 5'd0} +: 32] = apb.pwdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_map_data_o <= '0;
            col_map_addr_o <= '0;
            col_map_wen_o  <= 1'b0;
            ch_map_data_o  <= '0;
            ch_map_addr_o  <= '0;
            ch_map_wen_o   <= 1'b0;
            ch_t_data_o    <= '0;
            ch_t_addr_o    <= '0;
            ch_t_wen_o     <= 1'b0;
            apb.prdata_o   <= '0;
            rgn_q          <= NONE;
            word_q         <= '0;
            wr_q           <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            col_map_wen_o <= 1'b0;
            ch_map_wen_o  <= 1'b0;
            ch_t_wen_o    <= 1'b0;
            if ((setup_ld || map_wr) && !dec_err) begin
                case (dec_region)
                    COL:     col_map_addr_o <= dec_map_idx;
                    CH:      ch_map_addr_o  <= dec_map_idx;
                    CT:      ch_t_addr_o    <= dec_ct_idx;
                    default: ;
                endcase
            end
            if (map_wr) begin
                if (dec_region == COL) begin
                    col_map_data_o <= apb.pwdata_i[7:0];
                    col_map_wen_o  <= 1'b1;
                end else begin
                    ch_map_data_o  <= apb.pwdata_i[7:0];
                    ch_map_wen_o   <= 1'b1;
                end
            end
            if (start_wait) begin
                rgn_q  <= dec_region;
                word_q <= dec_word;
                wr_q   <= apb.pwrite_i;
            end
            if (bad) begin
                err_q        <= 1'b1;
                apb.prdata_o <= '0;
            end else if (map_wr || start_wait) begin
                err_q <= 1'b0;
            end
            if (rd_cap) begin
                case (rgn_q)
                    COL:     apb.prdata_o <= {24'h0, col_map_data_i};
                    CH:      apb.prdata_o <= {24'h0, ch_map_data_i};
                    default: apb.prdata_o <= ch_t_data_i[{word_q, 5'd0} +: 32];
                endcase
            end
            if (ct_wr) begin
                ch_t_data_o <= ct_merged;
                ch_t_wen_o  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_vgachargen_ctrl.sv
// Bench for apb_vgachargen_ctrl: directed cases plus random APB traffic checked
// against an address-map reference model and synchronous-read memory models.
module tb_apb_vgachargen_ctrl;
    localparam int ADDR_W = 16;
    localparam int MDEP   = 2400;
    localparam int CDEP   = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_vgachargen_ctrl_if #(.ADDR_W(ADDR_W)) apb();

    logic [7:0]   col_wdata, col_rd, ch_wdata, ch_rd;
    logic [11:0]  col_addr, ch_addr;
    logic         col_wen, ch_wen, ct_wen;
    logic [127:0] ct_wdata, ct_rd;
    logic [6:0]   ct_addr;

    apb_vgachargen_ctrl #(.ADDR_W(ADDR_W), .MAP_DEPTH(MDEP), .CT_DEPTH(CDEP)) dut (
        .clk_i(clk), .rst_ni(rst_n), .apb(apb.slave),
        .col_map_data_o(col_wdata), .col_map_addr_o(col_addr), .col_map_wen_o(col_wen), .col_map_data_i(col_rd),
        .ch_map_data_o(ch_wdata), .ch_map_addr_o(ch_addr), .ch_map_wen_o(ch_wen), .ch_map_data_i(ch_rd),
        .ch_t_data_o(ct_wdata), .ch_t_addr_o(ct_addr), .ch_t_wen_o(ct_wen), .ch_t_data_i(ct_rd)
    );

    // synchronous-read memories seen by the DUT
    logic [7:0]   col_mem [MDEP] = '{default: 8'h00};
    logic [7:0]   ch_mem  [MDEP] = '{default: 8'h00};
    logic [127:0] ct_mem  [CDEP] = '{default: 128'h0};
    always @(posedge clk) begin
        if (col_wen) col_mem[col_addr] <= col_wdata;
        if (ch_wen)  ch_mem[ch_addr]   <= ch_wdata;
        if (ct_wen)  ct_mem[ct_addr]   <= ct_wdata;
        col_rd <= col_mem[col_addr];
        ch_rd  <= ch_mem[ch_addr];
        ct_rd  <= ct_mem[ct_addr];
    end

    // write-strobe monitor
    int           n_col_wen = 0, n_ch_wen = 0, n_ct_wen = 0;
    logic [11:0]  last_map_addr = '0;
    logic [7:0]   last_map_data = '0;
    logic [6:0]   last_ct_addr = '0;
    logic [127:0] last_ct_data = '0;
    always @(negedge clk) begin
        if (col_wen) begin n_col_wen <= n_col_wen + 1; last_map_addr <= col_addr; last_map_data <= col_wdata; end
        if (ch_wen)  begin n_ch_wen  <= n_ch_wen + 1;  last_map_addr <= ch_addr;  last_map_data <= ch_wdata;  end
        if (ct_wen)  begin n_ct_wen  <= n_ct_wen + 1;  last_ct_addr  <= ct_addr;  last_ct_data  <= ct_wdata;  end
    end

    // reference model of memory contents
    logic [7:0]   exp_col [MDEP] = '{default: 8'h00};
    logic [7:0]   exp_ch  [MDEP] = '{default: 8'h00};
    logic [127:0] exp_ct  [CDEP] = '{default: 128'h0};

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // region: 0 colour, 1 char, 2 glyph, 3 invalid
    task automatic ref_decode(input logic [15:0] addr, output int rgn, output int idx, output int word);
        int a;
        a = int'(addr) & 32'hFFFC;
        rgn = 3; idx = 0; word = 0;
        if (a <= 32'h257C) begin
            rgn = 0; idx = a / 4;
        end else if (a >= 32'h4000 && a <= 32'h657C) begin
            rgn = 1; idx = (a - 32'h4000) / 4;
        end else if (a >= 32'h8000 && a <= 32'h87FC) begin
            rgn = 2; idx = (a - 32'h8000) / 16; word = (a / 4) % 4;
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = wr;
        apb.paddr_i = addr; apb.pwdata_i = wdata;
        @(posedge clk); #1 apb.penable_i = 1'b1;
        waits = 0; rdata = '0; err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (apb.pready_o) begin
                rdata = apb.prdata_o; err = apb.pslverr_o;
                break;
            end
            waits++;
        end
        @(posedge clk); #1 apb.psel_i = 1'b0; apb.penable_i = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
        int rgn, idx, word, waits, c0, h0, t0, exp_waits;
        logic [31:0] rdata;
        logic err;
        ref_decode(addr, rgn, idx, word);
        c0 = n_col_wen; h0 = n_ch_wen; t0 = n_ct_wen;
        apb_xfer(wr, addr, wdata, rdata, err, waits);
        exp_waits = (rgn == 3 || (wr && rgn < 2)) ? 1 : 2;
        chk({tag, "/err"}, 128'(err), 128'(rgn == 3));
        chk({tag, "/waits"}, 128'(waits), 128'(exp_waits));
        if (rgn == 3) begin
            chk({tag, "/rdata"}, 128'(rdata), 128'h0);
            chk({tag, "/wen"}, 128'(n_col_wen + n_ch_wen + n_ct_wen - c0 - h0 - t0), 128'h0);
        end else if (wr) begin
            if (rgn == 0) exp_col[idx] = wdata[7:0];
            if (rgn == 1) exp_ch[idx]  = wdata[7:0];
            if (rgn == 2) exp_ct[idx][word*32 +: 32] = wdata;
            chk({tag, "/wen"}, 128'({n_col_wen - c0, n_ch_wen - h0, n_ct_wen - t0}),
                128'({32'(rgn == 0), 32'(rgn == 1), 32'(rgn == 2)}));
            if (rgn < 2) begin
                chk({tag, "/maddr"}, 128'(last_map_addr), 128'(idx));
                chk({tag, "/mdata"}, 128'(last_map_data), 128'(wdata[7:0]));
            end else begin
                chk({tag, "/taddr"}, 128'(last_ct_addr), 128'(idx));
                chk({tag, "/tdata"}, last_ct_data, exp_ct[idx]);
            end
        end else begin
            if (rgn == 0) chk({tag, "/rdata"}, 128'(rdata), 128'(exp_col[idx]));
            if (rgn == 1) chk({tag, "/rdata"}, 128'(rdata), 128'(exp_ch[idx]));
            if (rgn == 2) chk({tag, "/rdata"}, 128'(rdata), 128'(exp_ct[idx][word*32 +: 32]));
            chk({tag, "/wen"}, 128'(n_col_wen + n_ch_wen + n_ct_wen - c0 - h0 - t0), 128'h0);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({apb.pready_o, apb.pslverr_o, apb.prdata_o, col_wen, ch_wen, ct_wen,
                     col_addr, ch_addr, ct_addr, col_wdata, ch_wdata});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        int k, t0;
        apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
        apb.paddr_i = '0; apb.pwdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", out_vec(), 128'h0);
        chk("reset_ctdata", ct_wdata, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("chmap_wr", 1'b1, 16'h4000, 32'h0000_0041);
        do_op("chmap_rd", 1'b0, 16'h4000, 32'h0);
        do_op("col_last", 1'b1, 16'h257C, 32'hFFFF_FF1F);
        do_op("col_oob", 1'b1, 16'h2580, 32'h0000_0055);
        do_op("col_last_rd", 1'b0, 16'h257C, 32'h0);
        do_op("bad_rd", 1'b0, 16'hC000, 32'h0);
        do_op("glyph5_wr", 1'b1, 16'h8058, 32'hDEAD_BEEF);
        chk("glyph5_lanes", last_ct_data, {32'h0, 32'hDEAD_BEEF, 64'h0});
        do_op("glyph5_rd", 1'b0, 16'h8058, 32'h0);
        for (int i = 0; i < 4; i++)
            do_op("glyph0_wr", 1'b1, 16'(16'h8000 + 4 * i), 32'h1111_1111 * (i + 1));
        chk("glyph0_entry", last_ct_data, 128'h44444444_33333333_22222222_11111111);
        do_op("glyph0_rd", 1'b0, 16'h8000, 32'h0);

        // reset asserted while a glyph write sits in WAIT
        t0 = n_ct_wen;
        apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
        apb.paddr_i = 16'h8024; apb.pwdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1 apb.penable_i = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", out_vec(), 128'h0);
        chk("rst_mid_ctdata", ct_wdata, 128'h0);
        apb.psel_i = 1'b0; apb.penable_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_no_wen", 128'(n_ct_wen - t0), 128'h0);
        do_op("rst_after_rd", 1'b0, 16'h8024, 32'h0);
        do_op("rst_after_wr", 1'b1, 16'h8024, 32'h1234_5678);
        do_op("rst_after_rd2", 1'b0, 16'h8024, 32'h0);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1:    a = 16'(4 * (($urandom_range(0, 3) == 0) ? 2399 : $urandom_range(0, 7)));
                2, 3:    a = 16'(16'h4000 + 4 * (($urandom_range(0, 3) == 0) ? 2399 : $urandom_range(0, 7)));
                4, 5, 6: a = 16'(16'h8000 + 16 * (($urandom_range(0, 7) == 0) ? 127 : $urandom_range(0, 7))
                                 + 4 * $urandom_range(0, 3));
                default: begin
                    case ($urandom_range(0, 4))
                        0:       a = 16'(16'h2580 + 4 * $urandom_range(0, 15));
                        1:       a = 16'h6580;
                        2:       a = 16'(16'h8800 + 4 * $urandom_range(0, 63));
                        3:       a = 16'(16'hC000 + 4 * $urandom_range(0, 255));
                        default: a = 16'h3000;
                    endcase
                end
            endcase
            a = a | 16'($urandom_range(0, 3));
            d = $urandom;
            do_op("rnd", 1'($urandom_range(0, 1)), a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
